top_polyphase_fir: RTL and testbench

- Two-phase polyphase FIR front end.
- Takes one signed sample per clock and splits the stream into even and odd phases.
- Runs a 2-tap sub-filter on each phase and emits both sub-filter outputs together once every two clocks.
- Sits ahead of the decimation/summing stage; the downstream block forms y_even+y_odd when it needs the full 4-tap decimated result.

---
 rtl/top_polyphase_fir.sv | 77 +++++++
 tb/tb_top_polyphase_fir.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/top_polyphase_fir.sv
// Two-phase polyphase FIR front end: even/odd 2-tap sub-filters, one output pair per two clocks.
// Define POLY_FIR_SAT_EN to saturate outputs; otherwise outputs wrap to DATA_W bits.
module top_polyphase_fir #(
  parameter int                       DATA_W = 16,
  parameter int                       COEF_W = 16,
  parameter logic signed [COEF_W-1:0] H0     = 1,
  parameter logic signed [COEF_W-1:0] H1     = 2,
  parameter logic signed [COEF_W-1:0] H2     = 3,
  parameter logic signed [COEF_W-1:0] H3     = 4,
  parameter int                       SHIFT  = 0
) (
  input  logic                     clk_2f,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y_even,
  output logic signed [DATA_W-1:0] y_odd,
  output logic                     valid_out
);

  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic                     phase;
  logic signed [DATA_W-1:0] xe0, xe1, xo1;
  logic signed [PW-1:0]     p_e0, p_e1, p_o0, p_o1;
  logic signed [SW-1:0]     sum_e, sum_o, sh_e, sh_o;

  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [SW-1:0] v);
`ifdef POLY_FIR_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
`endif
    return v[DATA_W-1:0];
  endfunction

  // The odd sub-filter uses the live sample as its newest tap, so both
  // sums are ready on the edge that captures the odd sample.
  always_comb begin
    p_e0  = PW'(H0) * PW'(xe0);
    p_e1  = PW'(H2) * PW'(xe1);
    p_o0  = PW'(H1) * PW'(x_in);
    p_o1  = PW'(H3) * PW'(xo1);
    sum_e = SW'(p_e0) + SW'(p_e1);
    sum_o = SW'(p_o0) + SW'(p_o1);
    sh_e  = sum_e >>> SHIFT;
    sh_o  = sum_o >>> SHIFT;
  end

  // valid_out is a one-cycle strobe with no backpressure: the sink must
  // take y_even/y_odd in the cycle valid_out=1; they hold until the next pair.
  always_ff @(posedge clk_2f) begin
    if (rst) begin
      phase     <= 1'b0;
      xe0       <= '0;
      xe1       <= '0;
      xo1       <= '0;
      y_even    <= '0;
      y_odd     <= '0;
      valid_out <= 1'b0;
    end else begin
      phase <= ~phase;
      if (!phase) begin
        xe1       <= xe0;
        xe0       <= x_in;
        valid_out <= 1'b0;
      end else begin
        y_even    <= narrow(sh_e);
        y_odd     <= narrow(sh_o);
        xo1       <= x_in;
        valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_top_polyphase_fir.sv
// Scoreboard bench for top_polyphase_fir: default instance plus a SHIFT=2 instance on the same stream.
module tb_top_polyphase_fir;

  localparam longint C0 = 1, C1 = 2, C2 = 3, C3 = 4;

  logic        clk_2f;
  logic        rst;
  logic [15:0] x_in;
  logic [15:0] y_even, y_odd, y_even_s2, y_odd_s2;
  logic        valid_out, valid_s2;

  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  longint      hist[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  top_polyphase_fir dut (
    .clk_2f(clk_2f), .rst(rst), .x_in(x_in),
    .y_even(y_even), .y_odd(y_odd), .valid_out(valid_out)
  );

  top_polyphase_fir #(.SHIFT(2)) dut_s2 (
    .clk_2f(clk_2f), .rst(rst), .x_in(x_in),
    .y_even(y_even_s2), .y_odd(y_odd_s2), .valid_out(valid_s2)
  );

  // clock / reset
  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  // reference model: the polyphase definition over the sample history since reset
  function automatic longint smp(int i);
    return (i >= 0) ? hist[i] : 64'sd0;
  endfunction

  function automatic logic [15:0] tb_narrow(longint v);
`ifdef POLY_FIR_SAT_EN
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic logic [31:0] ref_pair(int shift);
    int     n  = hist.size();
    longint se = C0 * smp(n-2) + C2 * smp(n-4);
    longint so = C1 * smp(n-1) + C3 * smp(n-3);
    return {tb_narrow(se >>> shift), tb_narrow(so >>> shift)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [15:0] v);
    @(negedge clk_2f);
    rst  = 1'b0;
    x_in = v;
    hist.push_back(longint'(signed'(v)));
    if (hist.size() % 2 == 0) begin
      exp_q.push_back(ref_pair(0));
      exp2_q.push_back(ref_pair(2));
    end
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) begin
      @(negedge clk_2f);
      rst  = 1'b1;
      x_in = 16'($urandom);
    end
    hist.delete();
  endtask

  // monitor / scoreboard
  always @(posedge clk_2f) begin
    #1;
    if (rst) begin
      chk("reset_outputs", {y_even, y_odd}, 32'h0);
      chk("reset_valid", {30'd0, valid_out, valid_s2}, 32'h0);
    end else begin
      if (valid_out || exp_q.size() != 0) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else if (!valid_out) begin
          chk("missing_valid", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end else chk("pair_shift0", {y_even, y_odd}, exp_q.pop_front());
      end
      if (valid_s2 || exp2_q.size() != 0) begin
        if (exp2_q.size() == 0) chk("unexpected_valid_s2", 32'd1, 32'd0);
        else if (!valid_s2) begin
          chk("missing_valid_s2", 32'd0, 32'd1);
          void'(exp2_q.pop_front());
        end else chk("pair_shift2", {y_even_s2, y_odd_s2}, exp2_q.pop_front());
      end
    end
  end

  // stimulus
  initial begin
    rst  = 1'b1;
    x_in = '0;
    do_reset(2);
    for (int i = 1; i <= 14; i++) drive(16'(i));

    do_reset(1);
    for (int i = 1; i <= 5; i++) drive(16'(i));
    do_reset(1);
    for (int i = 1; i <= 8; i++) drive(16'(i));

    do_reset(2);
    repeat (4) drive(16'hffff);
    do_reset(1);
    repeat (4) drive(16'h7fff);
    do_reset(1);
    repeat (4) drive(16'h8000);

    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       drive(16'h7fff);
        1:       drive(16'h8000);
        2:       drive(16'($urandom_range(0, 7)));
        default: drive(16'($urandom));
      endcase
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 2));
    end

    do_reset(2);
    @(negedge clk_2f);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("queue_drained_s2", 32'(exp2_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
